div_vl_inv: RTL

Sequential signed divider, the inverse datapath of the 32x32 multiplier.
- Takes a 64-bit signed dividend (a product) and a 32-bit signed divisor.
- Returns a 32-bit quotient and a 32-bit remainder, using truncating division.
- Same start/valid handshake and 33-cycle fixed latency as the multiplier, so the two blocks are interchangeable on one bench and can be chained for multiply-then-divide round-trip checks.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 33 +++
 rtl/div_vl_inv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state type for the sequential signed divider
package div_pkg;

  localparam int WIDTH   = 32;  // divisor / quotient / remainder width
  localparam int ITERS   = 32;  // restoring iterations, equals WIDTH
  localparam int LATENCY = 33;  // accept edge to valid, shared with the multiplier bench

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division step: compare, subtract, shift
//
// Purpose: given the running remainder and the next dividend bit, form the
// (W+1)-bit partial remainder and subtract the divisor when it fits.
// Ports:
//   rem_i   running remainder magnitude
//   bit_i   next dividend bit shifted in at the bottom
//   dvs_i   divisor magnitude
//   rem_o   remainder after this step
//   qbit_o  quotient bit produced by this step
module div_step import div_pkg::*; #(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         qbit_o
);

  logic [W:0] partial;
  logic [W:0] diff;

  assign partial = {rem_i, bit_i};

  // Subtract on the low W bits with the borrow kept in diff[W]. A set top
  // bit of the partial means it already exceeds any W-bit divisor, and the
  // low W bits of the difference are then exact modulo 2^W.
  assign diff   = {1'b0, partial[W-1:0]} - {1'b0, dvs_i};
  assign qbit_o = partial[W] | ~diff[W];
  assign rem_o  = qbit_o ? diff[W-1:0] : partial[W-1:0];

endmodule

// File: rtl/div_vl_inv.sv
// rtl/div_vl_inv.sv - sequential signed 2W/W truncating divider, fixed 33-cycle latency
//
// Purpose: divides a 2*WIDTH signed dividend by a WIDTH signed divisor with
// a restoring magnitude datapath, then applies signs and overflow checks.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-low
//   dvd    signed dividend (2*WIDTH)
//   dvs    signed divisor
//   start  request level; a rising edge in IDLE accepts an operation
//   quot   signed quotient (0 on error)
//   rem    signed remainder, sign follows dividend (0 on error)
//   err    divide-by-zero or quotient overflow, valid with valid
//   valid  one-cycle result strobe
//   busy   high from accept until valid
module div_vl_inv import div_pkg::*; #(
  parameter int WIDTH = div_pkg::WIDTH,
  parameter int ITERS = div_pkg::ITERS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   dvd,
  input  logic [WIDTH-1:0]     dvs,
  input  logic                 start,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem,
  output logic                 err,
  output logic                 valid,
  output logic                 busy
);

  localparam int CW = $clog2(ITERS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             start_q;
  logic [WIDTH-1:0] acc_q, acc_d;   // running remainder magnitude
  logic [WIDTH-1:0] lo_q, lo_d;     // dividend low bits out, quotient bits in
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             zflag_q, zflag_d, uflag_q, uflag_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             err_q, err_d, valid_q, valid_d, busy_q, busy_d;

  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dvs_in_mag;
  logic               accept;
  logic               sflag;
  logic [WIDTH-1:0]   step_rem;
  logic               step_qbit;

  // The most negative values map onto their unsigned magnitudes unchanged.
  assign dvd_mag    = dvd[2*WIDTH-1] ? -dvd : dvd;
  assign dvs_in_mag = dvs[WIDTH-1] ? -dvs : dvs;
  assign accept     = (state_q == IDLE) && start && !start_q;

  // A negative quotient may reach one further magnitude than a positive one.
  assign sflag = qneg_q ? (lo_q > {1'b1, {(WIDTH-1){1'b0}}})
                        : (lo_q > {1'b0, {(WIDTH-1){1'b1}}});

  div_step #(.W(WIDTH)) u_step (
    .rem_i  (acc_q),
    .bit_i  (lo_q[WIDTH-1]),
    .dvs_i  (dvs_mag_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    dvs_mag_d = dvs_mag_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    zflag_d   = zflag_q;
    uflag_d   = uflag_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    err_d     = err_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d     = dvd_mag[2*WIDTH-1:WIDTH];
          lo_d      = dvd_mag[WIDTH-1:0];
          dvs_mag_d = dvs_in_mag;
          qneg_d    = dvd[2*WIDTH-1] ^ dvs[WIDTH-1];
          rneg_d    = dvd[2*WIDTH-1];
          zflag_d   = (dvs == '0);
          // High half not below the divisor means the quotient needs more than WIDTH bits.
          uflag_d   = (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_in_mag);
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = ITER;
        end
      end
      ITER: begin
        // Runs the full count even for flagged operations to keep latency fixed.
        acc_d = step_rem;
        lo_d  = {lo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        err_d = zflag_q | uflag_q | sflag;
        if (zflag_q | uflag_q | sflag) begin
          quot_d = '0;
          rem_d  = '0;
        end else begin
          quot_d = qneg_q ? -lo_q : lo_q;
          rem_d  = rneg_q ? -acc_q : acc_q;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      acc_q     <= '0;
      lo_q      <= '0;
      dvs_mag_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      zflag_q   <= 1'b0;
      uflag_q   <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      dvs_mag_q <= dvs_mag_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      zflag_q   <= zflag_d;
      uflag_q   <= uflag_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign quot  = quot_q;
  assign rem   = rem_q;
  assign err   = err_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule
